// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sampler.
package acq_pkg;

  // Channel count and batch length are both fixed at 16 in this design.
  localparam int unsigned NCH       = 16;
  localparam int unsigned BATCH_LEN = 16;
  localparam int unsigned BCNT_W    = 4;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StOverflow
  } acq_state_e;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NCH-1:0] mask);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Sample-period divider: strobe fires when the count reaches the divisor, then wraps to 0.
module sample_strobe_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] divisor,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt_q;

  // Held off while cleared so the first active cycle starts from count 0.
  assign strobe = !clear && (cnt_q == divisor);

  // Period counter 0..divisor.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (strobe) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/acq_sampler.sv
// Multi-channel acquisition sampler: captures 16 samples per channel, then emits one packed
// word per enabled channel to a downstream FIFO in ascending channel order.
// Optional build macro ACQ_SAMPLER_TEST_PATTERN_EN replaces the sample inputs with an
// internal counter that advances once per strobe.
module acq_sampler
  import acq_pkg::*;
#(
  parameter int NCH   = acq_pkg::NCH,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acq_enable,
  input  logic             acq_reset,
  input  logic [DIV_W-1:0] clock_divisor,
  input  logic [NCH-1:0]   channel_enable,
  input  logic [NCH-1:0]   samples,
  input  logic             fifo_full,
  output logic [15:0]      fifo_data,
  output logic             fifo_write,
  output logic             fifo_overflow,
  output logic             running
);

  acq_state_e              state_q;
  logic [NCH-1:0]          en_snap_q;
  logic [DIV_W-1:0]        div_snap_q;
  logic [BCNT_W-1:0]       bcnt_q;
  logic [NCH-1:0][15:0]    shift_q;
  logic [NCH-1:0][15:0]    buf_q;
  logic [NCH-1:0]          pending_q;
  logic                    overflow_q;
  logic                    running_q;

  logic                    in_run;
  logic                    strobe;
  logic                    batch_done;
  logic                    has_pending;
  logic                    overflow_hit;
  logic [IDX_W-1:0]        pick;
  logic [NCH-1:0]          samp;

  assign in_run = (state_q == StRun);

  sample_strobe_gen #(
    .DIV_W(DIV_W)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_run),
    .divisor(div_snap_q),
    .strobe (strobe)
  );

`ifdef ACQ_SAMPLER_TEST_PATTERN_EN
  logic [15:0] tp_q;

  // Test-pattern counter: zero outside RUN, advances after every strobe.
  always_ff @(posedge clk) begin
    if (rst || !in_run) begin
      tp_q <= '0;
    end else if (strobe) begin
      tp_q <= tp_q + 1'b1;
    end
  end

  assign samp = NCH'(tp_q);
`else
  assign samp = samples;
`endif

  // Emission decode: lowest pending channel goes out, gated by FIFO space and RUN.
  always_comb begin
    has_pending  = |pending_q;
    pick         = lowest_set(pending_q);
    batch_done   = strobe && (bcnt_q == BCNT_W'(BATCH_LEN - 1));
    fifo_write   = has_pending && !fifo_full && in_run && !rst;
    overflow_hit = has_pending && fifo_full && in_run;
    fifo_data    = fifo_write ? buf_q[pick] : 16'h0000;
  end

  assign fifo_overflow = overflow_q;
  assign running       = running_q;

  // Control FSM with registered status outputs and run-time configuration snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
      en_snap_q  <= '0;
      div_snap_q <= '0;
    end else if (acq_reset) begin
      state_q    <= StIdle;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (acq_enable) begin
            state_q    <= StRun;
            running_q  <= 1'b1;
            en_snap_q  <= channel_enable;
            div_snap_q <= clock_divisor;
          end
        end
        StRun: begin
          // A blocked write is a lost word, which outranks a normal stop.
          if (overflow_hit) begin
            state_q    <= StOverflow;
            running_q  <= 1'b0;
            overflow_q <= 1'b1;
          end else if (!acq_enable) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end
        end
        StOverflow: begin
          state_q <= StOverflow;
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture path: shift samples in on each strobe, hand off a full batch, drain pending.
  // Anything outside RUN discards partial batches and undelivered words.
  always_ff @(posedge clk) begin
    if (rst || acq_reset || !in_run) begin
      bcnt_q    <= '0;
      shift_q   <= '0;
      buf_q     <= '0;
      pending_q <= '0;
    end else begin
      if (strobe) begin
        bcnt_q <= bcnt_q + 1'b1;
        // Right shift so sample k of the batch ends up in bit k after 16 strobes.
        for (int c = 0; c < NCH; c++) begin
          shift_q[c] <= {samp[c], shift_q[c][15:1]};
        end
      end
      // A new batch load replaces the mask; the word emitted this cycle came from the old buffer.
      if (batch_done) begin
        for (int c = 0; c < NCH; c++) begin
          buf_q[c] <= {samp[c], shift_q[c][15:1]};
        end
        pending_q <= en_snap_q;
      end else if (fifo_write) begin
        pending_q[pick] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acq_sampler.sv
// Self-checking bench for acq_sampler: vector table plus hand-written corner sequences,
// with a scoreboard of expected FIFO words and the cycles they must appear in.
module tb_acq_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acq_enable = 1'b0;
  logic        acq_reset = 1'b0;
  logic [7:0]  clock_divisor = 8'd0;
  logic [15:0] channel_enable = 16'h0000;
  logic [15:0] samples = 16'h0000;
  logic        fifo_full = 1'b0;
  logic [15:0] fifo_data;
  logic        fifo_write;
  logic        fifo_overflow;
  logic        running;

  acq_sampler #(
    .NCH  (16),
    .DIV_W(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .acq_enable    (acq_enable),
    .acq_reset     (acq_reset),
    .clock_divisor (clock_divisor),
    .channel_enable(channel_enable),
    .samples       (samples),
    .fifo_full     (fifo_full),
    .fifo_data     (fifo_data),
    .fifo_write    (fifo_write),
    .fifo_overflow (fifo_overflow),
    .running       (running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  div;
    logic [15:0] en;
    int          nbatch;
    bit          fixed;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[6];
  logic [15:0] pat[16];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          wr_base = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every write must match the next scoreboard entry in data and cycle.
  always @(negedge clk) begin
    if (fifo_write === 1'b1) begin
      wr_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %h expected no write (cycle %0d)", fifo_data,
                 cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("wr_data", 32'(fifo_data), 32'(e.data));
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench at #1 inside the first RUN cycle.
  task automatic start_run(input logic [7:0] div, input logic [15:0] en);
    clock_divisor  = div;
    channel_enable = en;
    acq_enable     = 1'b1;
    wr_base        = wr_cnt;
    tick(1);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++) pat[k] = 16'($urandom);
  endtask

  // Drives one batch of 16 sample periods; optionally queues the words it should produce.
  task automatic drive_batch(input logic [7:0] div, input logic [15:0] en, input bit push);
    for (int k = 0; k < 16; k++) begin
      samples = pat[k];
      if (k == 15 && push) begin
        int t;
        int idx;
        t   = cyc + int'(div);
        idx = 0;
        for (int c = 0; c < 16; c++) begin
          if (en[c]) begin
            exp_t e;
            for (int b = 0; b < 16; b++) e.data[b] = pat[b][c];
            e.cyc = t + 1 + idx;
            sbq.push_back(e);
            idx++;
          end
        end
      end
      tick(int'(div) + 1);
    end
  endtask

  // Called at T+1: let the k writes drain, stop during the last one, then verify.
  task automatic finish_run(input string name, input int k, input int exp_wr);
    tick(k > 0 ? k - 1 : 0);
    acq_enable = 1'b0;
    check({name, "_running"}, 32'(running), 32'd1);
    tick(2);
    check({name, "_stopped"}, 32'(running), 32'd0);
    check({name, "_drained"}, sbq.size(), 0);
    check({name, "_wr_count"}, wr_cnt - wr_base, exp_wr);
    check({name, "_no_ovf"}, 32'(fifo_overflow), 32'd0);
  endtask

  initial begin
    vecs[0] = '{div: 8'd0, en: 16'h0003, nbatch: 1, fixed: 1'b1};
    vecs[1] = '{div: 8'd3, en: 16'h8000, nbatch: 2, fixed: 1'b0};
    vecs[2] = '{div: 8'd0, en: 16'hFFFF, nbatch: 2, fixed: 1'b0};
    vecs[3] = '{div: 8'd1, en: 16'h0000, nbatch: 1, fixed: 1'b0};
    vecs[4] = '{div: 8'd2, en: 16'hA5A5, nbatch: 1, fixed: 1'b0};
    vecs[5] = '{div: 8'd0, en: 16'h0001, nbatch: 3, fixed: 1'b0};

    tick(3);
    check("rst_write", 32'(fifo_write), 32'd0);
    rst = 1'b0;
    tick(1);
    check("rst_data", 32'(fifo_data), 32'd0);
    check("rst_ovf", 32'(fifo_overflow), 32'd0);
    check("rst_running", 32'(running), 32'd0);

    // Table-driven runs.
    for (int v = 0; v < 6; v++) begin
      start_run(vecs[v].div, vecs[v].en);
      for (int b = 0; b < vecs[v].nbatch; b++) begin
        if (vecs[v].fixed) begin
          // ch0 toggles 1,0,1,... and ch1 is held high: words 5555 then FFFF.
          for (int k = 0; k < 16; k++) pat[k] = (k % 2 == 0) ? 16'h0003 : 16'h0002;
        end else begin
          fill_random();
        end
        drive_batch(vecs[v].div, vecs[v].en, 1'b1);
      end
      finish_run($sformatf("vec%0d", v), $countones(vecs[v].en),
                 vecs[v].nbatch * $countones(vecs[v].en));
    end

    // Full FIFO on the first emission cycle: sticky overflow until acq_reset.
    fifo_full = 1'b1;
    start_run(8'd0, 16'h0003);
    fill_random();
    drive_batch(8'd0, 16'h0003, 1'b0);
    check("ovf_nowrite", 32'(fifo_write), 32'd0);
    tick(1);
    check("ovf_flag", 32'(fifo_overflow), 32'd1);
    check("ovf_running", 32'(running), 32'd0);
    acq_enable = 1'b0;
    tick(2);
    acq_enable = 1'b1;
    fifo_full  = 1'b0;
    tick(3);
    check("ovf_sticky", 32'(fifo_overflow), 32'd1);
    check("ovf_still_stopped", 32'(running), 32'd0);
    acq_reset = 1'b1;
    tick(1);
    check("ovf_cleared", 32'(fifo_overflow), 32'd0);
    check("acq_reset_overrides", 32'(running), 32'd0);
    acq_reset  = 1'b0;
    acq_enable = 1'b0;
    tick(2);

    // Stop after 7 strobes: partial batch discarded, next batch starts at bit 0.
    start_run(8'd0, 16'h0001);
    for (int k = 0; k < 7; k++) begin
      samples = 16'($urandom);
      tick(1);
    end
    acq_enable = 1'b0;
    tick(2);
    check("partial_stopped", 32'(running), 32'd0);
    start_run(8'd0, 16'h0001);
    fill_random();
    drive_batch(8'd0, 16'h0001, 1'b1);
    finish_run("after_partial", 1, 1);

    // rst in the middle of a batch: nothing captured survives.
    start_run(8'd0, 16'hFFFF);
    for (int k = 0; k < 10; k++) begin
      samples = 16'($urandom);
      tick(1);
    end
    rst        = 1'b1;
    acq_enable = 1'b0;
    tick(1);
    check("midrst_running", 32'(running), 32'd0);
    rst = 1'b0;
    check("midrst_nowrite", 32'(fifo_write), 32'd0);
    tick(2);
    start_run(8'd0, 16'h0101);
    fill_random();
    drive_batch(8'd0, 16'h0101, 1'b1);
    finish_run("after_rst", 2, 2);

`ifdef ACQ_SAMPLER_TEST_PATTERN_EN
    // Internal counter as the sample source: ch0 sees 0,1,0,1,... -> AAAA.
    start_run(8'd0, 16'h0001);
    begin
      exp_t e;
      e.data = 16'hAAAA;
      e.cyc  = cyc + 16;
      sbq.push_back(e);
    end
    tick(16);
    finish_run("test_pattern", 1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acq_sampler.md
ACQ_SAMPLER -- requirements
Module: acq_sampler

Interface
REQ-001 SHALL have parameter NCH, default 16, number of input channels (fixed at 16 in this design).
REQ-002 SHALL have parameter DIV_W, default 8, width of clock_divisor.
REQ-003 SHALL have ports clk input 1 system clock and rst input 1 reset; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have acq_enable input 1, start/continue acquisition.
REQ-005 SHALL have acq_reset input 1, abort acquisition and clear overflow.
REQ-006 SHALL have clock_divisor input DIV_W, sample period minus one, in clk cycles.
REQ-007 SHALL have channel_enable input NCH, per-channel capture enable.
REQ-008 SHALL have samples input NCH, already-synchronised channel levels.
REQ-009 SHALL have fifo_full input 1, downstream FIFO cannot accept a word.
REQ-010 SHALL have fifo_data output 16, packed word of one channel.
REQ-011 SHALL have fifo_write output 1, fifo_data valid and written this cycle.
REQ-012 SHALL have fifo_overflow output 1, sticky overflow flag.
REQ-013 SHALL have running output 1, high in RUN state.

Function
REQ-014 SHALL implement states IDLE, RUN, OVERFLOW.
REQ-015 IDLE->RUN when acq_enable=1 and acq_reset=0; channel_enable and clock_divisor SHALL be snapshotted that cycle and held for the run.
REQ-016 RUN->IDLE when acq_enable=0; partial batch and pending words SHALL be discarded.
REQ-017 Strobe counter SHALL count 0..divisor, asserting sample strobe when count==divisor then wrapping to 0; divisor 0 gives strobe every clk; first strobe on first RUN cycle with count 0 equal to divisor, else after divisor+1 cycles.
REQ-018 On each strobe, per-channel shift register SHALL capture samples[c]; sample k (0..15) of a batch lands in bit k.
REQ-019 On the 16th strobe (cycle T), all 16 completed words SHALL load into a holding buffer and pending mask SHALL load the channel_enable snapshot.
REQ-020 Each cycle from T+1 while pending is nonzero, lowest set channel SHALL be emitted: fifo_write=1, fifo_data=its word, bit cleared; enabled count k gives writes in T+1..T+k, ascending channel order.
REQ-021 fifo_write SHALL be pending!=0 AND fifo_full=0 AND state RUN (combinational on fifo_full).
REQ-022 If pending!=0 and fifo_full=1 in RUN, no write SHALL occur and state SHALL go OVERFLOW with fifo_overflow=1 next cycle.
REQ-023 When a batch load coincides with emission of the last pending word, emitted word SHALL come from the previous buffer contents.
REQ-024 channel_enable snapshot all-zero SHALL run with no writes ever.
REQ-025 OVERFLOW SHALL hold capture and writes off, ignore acq_enable, and exit only via acq_reset or rst.
REQ-026 acq_reset SHALL, in any state, force IDLE next cycle, clear counters, pending, buffer and fifo_overflow; it overrides acq_enable.

Reset
REQ-027 rst SHALL force IDLE, fifo_write=0, fifo_data=0, fifo_overflow=0, running=0, all counters, shift registers and pending mask to 0.
REQ-028 rst mid-batch SHALL discard all captured data; no write in the cycle after rst.

Configuration
REQ-029 Macro ACQ_SAMPLER_TEST_PATTERN_EN defined: samples SHALL be replaced by a 16-bit counter cleared on RUN entry and incremented after each strobe; undefined: samples port used directly, no counter logic.

Structure
REQ-030 Package acq_pkg SHALL hold state enum, NCH, batch length constant 16.
REQ-031 Divisor counter SHALL be sub-module sample_strobe_gen (clk, rst, clear, divisor, strobe).

Verification
REQ-032 divisor=0, enable=16'h0003, samples ch0 toggling 1,0,... ch1=1 -> writes T+1:16'h5555, T+2:16'hFFFF, then none until next batch.
REQ-033 divisor=3, enable=16'h8000 -> strobes every 4 clk, one write of ch15 word per 64 clk.
REQ-034 divisor=0, enable=16'hFFFF -> 16 contiguous writes per batch, no gap, no overflow, boundary REQ-023 checked.
REQ-035 fifo_full=1 at T+1 -> no write, fifo_overflow=1 at T+2, stays with acq_enable toggled; acq_reset clears it next cycle.
REQ-036 acq_enable low after 7 strobes then high -> no write from partial batch; next batch starts at bit 0.
REQ-037 With ACQ_SAMPLER_TEST_PATTERN_EN, enable=16'h0001, divisor=0 -> first word 16'hAAAA.
